// File: rtl/alu_pkg.sv
// Shared constants for the ALU micro-sequencer: opcodes, register select codes, state encoding.
// Build option ALU_FLAGS_WB_EN enables the flags write-back state (S_WRF).
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_INV = 3'b111;

  localparam logic [1:0] RS_NONE = 2'b00;
  localparam logic [1:0] RS_X1   = 2'b01;
  localparam logic [1:0] RS_X2   = 2'b10;
  localparam logic [1:0] RS_X3   = 2'b11;

  localparam logic [1:0] WS_NONE = 2'b00;
  localparam logic [1:0] WS_RES  = 2'b01;
  localparam logic [1:0] WS_FLG  = 2'b10;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LDA  = 3'd1;
  localparam state_t S_LDB  = 3'd2;
  localparam state_t S_EXEC = 3'd3;
  localparam state_t S_WRR  = 3'd4;
  localparam state_t S_WRF  = 3'd5;
endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: unary ops skip the second operand load.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] opcode,
  output logic       is_unary,
  output logic       is_invalid
);
  assign is_unary   = (opcode == OP_NOT) || (opcode == OP_INC);
  assign is_invalid = (opcode == OP_INV);
endmodule

// File: rtl/alu_useq.sv
// ALU micro-sequencer: loads operands over a shared bus, runs one EXEC cycle, writes back.
// Build option ALU_FLAGS_WB_EN adds the flags write-back step after the result write.
module alu_useq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       bus_gnt,
  output logic       ready,
  output logic [1:0] rs,
  output logic [1:0] ws,
  output logic [2:0] alu_op,
  output logic       done,
  output logic       err
);
  state_t     state, nxt;
  logic [2:0] op_q;
  logic       unary_q;
  logic       is_unary, is_invalid;
  logic       accept;

  alu_op_decode u_dec (
    .opcode     (opcode),
    .is_unary   (is_unary),
    .is_invalid (is_invalid)
  );

  assign accept = (state == S_IDLE) && start;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start && !is_invalid) nxt = S_LDA;
      S_LDA:  if (bus_gnt) nxt = unary_q ? S_EXEC : S_LDB;
      S_LDB:  if (bus_gnt) nxt = S_EXEC;
      S_EXEC: nxt = S_WRR;
`ifdef ALU_FLAGS_WB_EN
      S_WRR:  if (bus_gnt) nxt = S_WRF;
      S_WRF:  if (bus_gnt) nxt = S_IDLE;
`else
      S_WRR:  if (bus_gnt) nxt = S_IDLE;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // Unary-ness is captured with the opcode so the decoder only ever sees the live input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= 3'b000;
      unary_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= nxt;
      err   <= accept && is_invalid;
      if (accept && !is_invalid) begin
        op_q    <= opcode;
        unary_q <= is_unary;
      end
    end
  end

  always_comb begin
    ready  = (state == S_IDLE);
    rs     = (state == S_LDA) ? RS_X1 : (state == S_LDB) ? RS_X2 : RS_NONE;
    alu_op = (state == S_EXEC) ? op_q : 3'b000;
`ifdef ALU_FLAGS_WB_EN
    ws   = (state == S_WRR) ? WS_RES : (state == S_WRF) ? WS_FLG : WS_NONE;
    done = (state == S_WRF) && bus_gnt;
`else
    ws   = (state == S_WRR) ? WS_RES : WS_NONE;
    done = (state == S_WRR) && bus_gnt;
`endif
  end
endmodule

// File: tb/tb_alu_useq.sv
// Directed-vector bench for alu_useq; expectations follow ALU_FLAGS_WB_EN when it is defined.
module tb_alu_useq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       bus_gnt = 1'b0;
  logic       ready, done, err;
  logic [1:0] rs, ws;
  logic [2:0] alu_op;

  int nvec = 0;
  int nbad = 0;

`ifdef ALU_FLAGS_WB_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  // observed word: {ready, rs, ws, alu_op, done, err}
  localparam logic [9:0] IDLE_O = 10'b1_00_00_000_0_0;
  localparam logic [9:0] ERR_O  = 10'b1_00_00_000_0_1;
  localparam logic [9:0] LDA_O  = 10'b0_01_00_000_0_0;
  localparam logic [9:0] LDB_O  = 10'b0_10_00_000_0_0;
  localparam logic [9:0] WRR_N  = 10'b0_00_01_000_0_0;
  localparam logic [9:0] WRR_D  = 10'b0_00_01_000_1_0;
  localparam logic [9:0] WRF_N  = 10'b0_00_10_000_0_0;
  localparam logic [9:0] WRF_D  = 10'b0_00_10_000_1_0;

  typedef struct packed {
    logic       r;
    logic       s;
    logic [2:0] op;
    logic       g;
    logic [9:0] e;
  } vec_t;

  wire [9:0] obs = {ready, rs, ws, alu_op, done, err};

  alu_useq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .opcode  (opcode),
    .bus_gnt (bus_gnt),
    .ready   (ready),
    .rs      (rs),
    .ws      (ws),
    .alu_op  (alu_op),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] op,
                              input logic g, input logic [9:0] e);
    vec_t v;
    v.r = r; v.s = s; v.op = op; v.g = g; v.e = e;
    return v;
  endfunction

  function automatic logic [9:0] exec_o(input logic [2:0] op);
    return {1'b0, 4'b0000, op, 2'b00};
  endfunction

  // Advance one cycle, then drive this cycle's inputs; outputs settle before the caller samples.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.r; start = v.s; opcode = v.op; bus_gnt = v.g;
    #1;
  endtask

  task automatic test_reset();
    vec_t q[$];
    q.push_back(mk(1, 1, 3'b111, 1, IDLE_O));
    q.push_back(mk(1, 1, 3'b000, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      nvec++;
      if (obs !== q[i].e) begin
        nbad++;
        $display("FAIL reset cyc%0d got %b exp %b", i, obs, q[i].e);
      end
    end
  endtask

  task automatic test_add();
    vec_t q[$];
    q.push_back(mk(0, 1, 3'b000, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDA_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDB_O));
    q.push_back(mk(0, 0, 3'b000, 1, exec_o(3'b000)));
    if (FLAGS) begin
      q.push_back(mk(0, 0, 3'b000, 1, WRR_N));
      q.push_back(mk(0, 0, 3'b000, 1, WRF_D));
    end else q.push_back(mk(0, 0, 3'b000, 1, WRR_D));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      nvec++;
      if (obs !== q[i].e) begin
        nbad++;
        $display("FAIL add cyc%0d got %b exp %b", i, obs, q[i].e);
      end
    end
  endtask

  task automatic test_not();
    vec_t q[$];
    q.push_back(mk(0, 1, 3'b101, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDA_O));
    q.push_back(mk(0, 0, 3'b000, 1, exec_o(3'b101)));
    if (FLAGS) begin
      q.push_back(mk(0, 0, 3'b000, 1, WRR_N));
      q.push_back(mk(0, 0, 3'b000, 1, WRF_D));
    end else q.push_back(mk(0, 0, 3'b000, 1, WRR_D));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      nvec++;
      if (obs !== q[i].e) begin
        nbad++;
        $display("FAIL not cyc%0d got %b exp %b", i, obs, q[i].e);
      end
    end
  endtask

  task automatic test_invalid();
    vec_t q[$];
    q.push_back(mk(0, 1, 3'b111, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b111, 1, ERR_O));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      nvec++;
      if (obs !== q[i].e) begin
        nbad++;
        $display("FAIL invalid cyc%0d got %b exp %b", i, obs, q[i].e);
      end
    end
  endtask

  // SUB with grant withheld in LDB, EXEC with grant low, and a held write step.
  task automatic test_sub_stall();
    vec_t q[$];
    q.push_back(mk(0, 1, 3'b001, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDA_O));
    q.push_back(mk(0, 0, 3'b000, 0, LDB_O));
    q.push_back(mk(0, 0, 3'b000, 0, LDB_O));
    q.push_back(mk(0, 0, 3'b000, 0, LDB_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDB_O));
    q.push_back(mk(0, 0, 3'b000, 0, exec_o(3'b001)));
    q.push_back(mk(0, 0, 3'b000, 0, WRR_N));
    if (FLAGS) begin
      q.push_back(mk(0, 0, 3'b000, 1, WRR_N));
      q.push_back(mk(0, 0, 3'b000, 0, WRF_N));
      q.push_back(mk(0, 0, 3'b000, 1, WRF_D));
    end else q.push_back(mk(0, 0, 3'b000, 1, WRR_D));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      nvec++;
      if (obs !== q[i].e) begin
        nbad++;
        $display("FAIL sub_stall cyc%0d got %b exp %b", i, obs, q[i].e);
      end
    end
  endtask

  // Reset lands in EXEC of AND; a start coinciding with reset is dropped; OR then runs clean.
  task automatic test_rst_mid();
    vec_t q[$];
    q.push_back(mk(0, 1, 3'b010, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDA_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDB_O));
    q.push_back(mk(1, 0, 3'b000, 1, exec_o(3'b010)));
    q.push_back(mk(1, 1, 3'b011, 1, IDLE_O));
    q.push_back(mk(0, 1, 3'b011, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDA_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDB_O));
    q.push_back(mk(0, 0, 3'b000, 1, exec_o(3'b011)));
    if (FLAGS) begin
      q.push_back(mk(0, 0, 3'b000, 1, WRR_N));
      q.push_back(mk(0, 0, 3'b000, 1, WRF_D));
    end else q.push_back(mk(0, 0, 3'b000, 1, WRR_D));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      nvec++;
      if (obs !== q[i].e) begin
        nbad++;
        $display("FAIL rst_mid cyc%0d got %b exp %b", i, obs, q[i].e);
      end
    end
  endtask

  // XOR accepted, then start/opcode toggled while busy: latched op must stay 100, one done only.
  task automatic test_start_busy();
    vec_t q[$];
    q.push_back(mk(0, 1, 3'b100, 1, IDLE_O));
    q.push_back(mk(0, 1, 3'b110, 0, LDA_O));
    q.push_back(mk(0, 1, 3'b110, 1, LDA_O));
    q.push_back(mk(0, 0, 3'b001, 1, LDB_O));
    q.push_back(mk(0, 0, 3'b001, 1, exec_o(3'b100)));
    if (FLAGS) begin
      q.push_back(mk(0, 0, 3'b000, 1, WRR_N));
      q.push_back(mk(0, 0, 3'b000, 1, WRF_D));
    end else q.push_back(mk(0, 0, 3'b000, 1, WRR_D));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      nvec++;
      if (obs !== q[i].e) begin
        nbad++;
        $display("FAIL start_busy cyc%0d got %b exp %b", i, obs, q[i].e);
      end
    end
  endtask

  // INC then OR, second start issued in the IDLE cycle right after done.
  task automatic test_back_to_back();
    vec_t q[$];
    q.push_back(mk(0, 1, 3'b110, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDA_O));
    q.push_back(mk(0, 0, 3'b000, 1, exec_o(3'b110)));
    if (FLAGS) begin
      q.push_back(mk(0, 0, 3'b000, 1, WRR_N));
      q.push_back(mk(0, 0, 3'b000, 1, WRF_D));
    end else q.push_back(mk(0, 0, 3'b000, 1, WRR_D));
    q.push_back(mk(0, 1, 3'b011, 1, IDLE_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDA_O));
    q.push_back(mk(0, 0, 3'b000, 1, LDB_O));
    q.push_back(mk(0, 0, 3'b000, 1, exec_o(3'b011)));
    if (FLAGS) begin
      q.push_back(mk(0, 0, 3'b000, 1, WRR_N));
      q.push_back(mk(0, 0, 3'b000, 1, WRF_D));
    end else q.push_back(mk(0, 0, 3'b000, 1, WRR_D));
    q.push_back(mk(0, 0, 3'b000, 1, IDLE_O));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      nvec++;
      if (obs !== q[i].e) begin
        nbad++;
        $display("FAIL back_to_back cyc%0d got %b exp %b", i, obs, q[i].e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_not();
    test_invalid();
    test_sub_stall();
    test_rst_mid();
    test_start_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
